// File: rtl/uart_pkg.sv
// uart_pkg: shared register map, CON bit positions and transmitter FSM states
package uart_pkg;
  localparam logic [31:0] TXD_OFS = 32'd0;
  localparam logic [31:0] CON_OFS = 32'd4;
  localparam int BUSY = 0;
  localparam int FULL = 1;
  localparam int OVF = 2;
  localparam int DONE = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: CPU MEM-stage load/store bus as seen by a peripheral
interface uart_tx_port_if;
  logic rd, wr;
  logic [31:0] addr, wdata, rdata;
  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_port_tx_fifo.sv
// tx_fifo: byte FIFO that ignores pushes when full and pops when empty
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     sysclk,
  input  logic                     Reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge sysclk or negedge Reset_n)
    if (!Reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage holds no reset; stale entries are never read once count is zero
  always_ff @(posedge sysclk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with a small byte FIFO
module uart_tx_port import uart_pkg::*; #(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 9600,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0018
) (
  input  logic           sysclk,
  input  logic           Reset_n,
  uart_tx_port_if.slave  bus,
  output logic           out
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  tx_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift, f_dout;
  logic [$clog2(FIFO_DEPTH):0] f_count;
  logic f_full, f_empty, push, pop, bit_end, busy, overflow, tx_done;
  logic txd_hit, con_hit, ovf_set, done_set;
  logic [31:0] con;
  assign txd_hit = bus.addr == BASE_ADDR + TXD_OFS;
  assign con_hit = bus.addr == BASE_ADDR + CON_OFS;
  assign push = bus.wr && txd_hit;
  assign ovf_set = push && f_full;
  assign bit_end = cnt == CW'(DIV - 1);
  assign pop = !f_empty && (state == IDLE || (state == STOP && bit_end));
  assign done_set = state == STOP && bit_end && f_empty;
  assign busy = state != IDLE || f_count != '0;
  assign out = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
  assign bus.rdata = (bus.rd && con_hit) ? con : '0;
  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .sysclk (sysclk),
    .Reset_n(Reset_n),
    .push   (push),
    .pop    (pop),
    .din    (bus.wdata[7:0]),
    .dout   (f_dout),
    .count  (f_count),
    .full   (f_full),
    .empty  (f_empty)
  );
  // CON status word as seen by a load
  always_comb begin
    con = '0;
    con[BUSY] = busy;
    con[FULL] = f_full;
    con[OVF] = overflow;
    con[DONE] = tx_done;
  end
  // next state: advance only at the end of a bit; STOP chains straight into START
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (f_empty ? IDLE : START) :
          !bit_end ? state :
          state == START ? DATA :
          state == DATA ? (idx == 3'd7 ? STOP : DATA) :
          (f_empty ? IDLE : START);
  end
  // state register
  always_ff @(posedge sysclk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= nxt;
  // baud counter, bit index and shift register
  always_ff @(posedge sysclk or negedge Reset_n)
    if (!Reset_n) begin
      cnt <= '0;
      idx <= '0;
      shift <= '0;
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      idx <= state != DATA ? 3'd0 : bit_end ? idx + 3'd1 : idx;
      shift <= pop ? f_dout : (state == DATA && bit_end) ? shift >> 1 : shift;
    end
  // sticky flags: a set in the same cycle as its clear wins
  always_ff @(posedge sysclk or negedge Reset_n)
    if (!Reset_n) begin
      overflow <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      overflow <= ovf_set || (overflow && !(bus.wr && con_hit && bus.wdata[OVF]));
      tx_done <= done_set || (tx_done && !(bus.rd && con_hit));
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: randomized and directed checks against a frame-timeline model
module tb_uart_tx_port;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] CON = BASE + 32'd4;
  localparam int DIV = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;
  logic sysclk = 1'b0;
  logic Reset_n = 1'b0;
  logic out;
  int checks = 0;
  int errors = 0;
  uart_tx_port_if bus();
  uart_tx_port #(.CLK_HZ(40), .BAUD(10), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .sysclk (sysclk),
    .Reset_n(Reset_n),
    .bus    (bus.slave),
    .out    (out)
  );
  always #5 sysclk = ~sysclk;

  logic [7:0] mq[$];
  bit m_act = 0;
  logic [7:0] m_byte = '0;
  int m_t = 0;
  bit m_ovf = 0;
  bit m_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
  endfunction

  always @(posedge sysclk or negedge Reset_n) begin : mdl
    bit txw, conr, conw, endf;
    int sz;
    if (!Reset_n) begin
      mq.delete();
      m_act = 0;
      m_t = 0;
      m_ovf = 0;
      m_done = 0;
    end else begin
      txw = bus.wr && bus.addr == BASE;
      conr = bus.rd && bus.addr == CON;
      conw = bus.wr && bus.addr == CON;
      sz = mq.size();
      endf = m_act && m_t == FRAME - 1;
      if (conr) m_done = 0;
      if (conw && bus.wdata[2]) m_ovf = 0;
      if ((!m_act || endf) && sz > 0) begin
        m_byte = mq.pop_front();
        m_act = 1;
        m_t = 0;
      end else if (endf) begin
        m_act = 0;
        m_done = 1;
      end else if (m_act) m_t++;
      if (txw) begin
        if (sz < DEPTH) mq.push_back(bus.wdata[7:0]);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge sysclk) begin : cmp
    logic [31:0] exp_rd;
    int sz;
    sz = mq.size();
    exp_rd = (bus.rd && bus.addr == CON) ?
             {28'b0, m_done, m_ovf, sz == DEPTH, m_act || sz != 0} : 32'b0;
    chk("out", {31'b0, out}, {31'b0, m_act ? fbit(m_byte, m_t / DIV) : 1'b1});
    chk("rdata", bus.rdata, exp_rd);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.wr = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    tick(1);
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.rd = 1'b1;
    bus.addr = a;
    #1 d = bus.rdata;
    tick(1);
    bus.rd = 1'b0;
    bus.addr = '0;
  endtask

  task automatic poll_idle(input string nm, output int n, output logic [31:0] d);
    n = 0;
    do begin
      bus_read(CON, d);
      n++;
    end while (d[0] && n < 1000);
    if (n >= 1000) chk({nm, "_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0] v;
    int n;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    tick(3);
    chk("reset_out", {31'b0, out}, 32'd1);
    bus.rd = 1'b1;
    bus.addr = CON;
    #1 chk("reset_rdata", bus.rdata, 32'd0);
    bus.rd = 1'b0;
    Reset_n = 1'b1;
    tick(2);
    bus_read(CON, d);
    chk("con_after_reset", d, 32'd0);

    bus_write(BASE, 32'h0000_00A5);
    tick(1);
    for (int i = 0; i < 10; i++) begin
      tick(2);
      v[i] = out;
      tick(2);
    end
    chk("a5_frame_bits", {22'b0, v}, {22'b0, 10'b1101001010});
    bus_read(CON, d);
    chk("done_set", d, 32'h8);
    bus_read(CON, d);
    chk("done_cleared", d, 32'h0);

    for (int i = 0; i < 5; i++) bus_write(BASE, 32'h10 + i);
    bus_read(CON, d);
    chk("five_busy_full", d, 32'h3);
    poll_idle("five", n, d);
    chk("five_polls", 32'(n + 1), 32'd198);
    chk("five_end_con", d, 32'h8);

    for (int i = 0; i < 5; i++) bus_write(BASE, 32'h60 + i);
    bus_write(BASE, 32'h3C);
    bus_read(CON, d);
    chk("ovf_set", d, 32'h7);
    bus_write(CON, 32'h4);
    bus_read(CON, d);
    chk("ovf_cleared", d, 32'h3);
    poll_idle("ovf_drain", n, d);
    chk("ovf_drain_con", d, 32'h8);

    bus_read(BASE, d);
    chk("txd_read_zero", d, 32'h0);
    bus_read(BASE + 32'd8, d);
    chk("other_read_zero", d, 32'h0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = $urandom;
      if (a == CON) a = 32'h0;
      bus_read(a, d);
      chk("rand_addr_zero", d, 32'h0);
    end
    bus.addr = CON;
    #1 chk("no_rd_zero", bus.rdata, 32'h0);
    tick(1);
    bus.addr = '0;

    for (int i = 0; i < 3; i++) bus_write(BASE, 32'hC0 + i);
    tick(50);
    Reset_n = 1'b0;
    #1 chk("midframe_reset_out", {31'b0, out}, 32'd1);
    tick(3);
    Reset_n = 1'b1;
    tick(1);
    bus_read(CON, d);
    chk("post_reset_con", d, 32'h0);
    tick(100);
    chk("post_reset_quiet", {31'b0, out}, 32'd1);

    bus_write(BASE, 32'h81);
    tick(40);
    bus_read(CON, d);
    chk("stop_edge_read", d, 32'h1);
    bus_read(CON, d);
    chk("done_survives_clear", d, 32'h8);

    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) bus_write(BASE, $urandom);
      else if (r < 25) bus_read(CON, d);
      else if (r < 28) bus_write(CON, $urandom);
      else if (r < 34) begin
        bus.rd = 1'($urandom);
        bus.wr = 1'($urandom);
        bus.addr = BASE - 32'd4 + 32'($urandom_range(0, 3)) * 32'd4;
        bus.wdata = $urandom;
        tick(1);
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.addr = '0;
      end else tick(1);
    end
    tick(FRAME * (DEPTH + 2));
    bus_read(CON, d);
    chk("final_idle", {31'b0, d[0]}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
